// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: data width, opcodes, FSM states.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. Push is ignored when full and pop is ignored when
// empty, so the caller may present requests without pre-qualifying them.
module alu_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy count; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the external combinational 4-bit ALU: buffers commands,
// feeds registered operands one at a time and holds each result for a
// valid/ready consumer. Optional accumulator forwarding is compiled in with
// the ALU_SEQ_ACC_EN macro (adds the cmd_use_acc port).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
`ifdef ALU_SEQ_ACC_EN
  input  logic             cmd_use_acc,
`endif
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [ALU_W-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ALU_W-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero
);

`ifdef ALU_SEQ_ACC_EN
  localparam int ENTRY_W = 2 * ALU_W + 3;
`else
  localparam int ENTRY_W = 2 * ALU_W + 2;
`endif

  seq_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] wdata_s, head_s;
  logic             full_s, empty_s, pop_s, capture_s, release_s;
  logic [ALU_W-1:0] head_a_s, head_b_s, sel_a_s;
  logic [1:0]       head_op_s;
  logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             res_valid_q, res_valid_d, res_carry_q, res_carry_d;
  logic             res_zero_q, res_zero_d;
  logic [ALU_W-1:0] res_data_q, res_data_d;

  // Entry layout, low to high: a, b, op [, use_acc].
`ifdef ALU_SEQ_ACC_EN
  logic [ALU_W-1:0] acc_q, acc_d;
  assign wdata_s = {cmd_use_acc, cmd_op, cmd_b, cmd_a};
  assign sel_a_s = head_s[ENTRY_W-1] ? acc_q : head_a_s;
`else
  assign wdata_s = {cmd_op, cmd_b, cmd_a};
  assign sel_a_s = head_a_s;
`endif
  assign head_a_s  = head_s[ALU_W-1:0];
  assign head_b_s  = head_s[2*ALU_W-1:ALU_W];
  assign head_op_s = head_s[2*ALU_W+1:2*ALU_W];

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Ready reflects registered occupancy only, so a full FIFO refuses even while popping.
  assign cmd_ready = !full_s;

  // Next-state logic: IDLE waits for work, EXEC lasts one cycle, RESP waits for the consumer.
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        capture_s = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          release_s = 1'b1;
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load operands on pop, capture ALU result at end of EXEC.
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
`ifdef ALU_SEQ_ACC_EN
    acc_d       = acc_q;
`endif
    if (pop_s) begin
      alu_a_d  = sel_a_s;
      alu_b_d  = head_b_s;
      alu_op_d = head_op_s;
    end else begin
      alu_a_d  = alu_a_q;
    end
    if (capture_s) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_zero_d  = alu_zero;
      // Carry is only meaningful for arithmetic; logic ops report 0.
      res_carry_d = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) ? alu_carry : 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc_d       = alu_out;
`endif
    end else if (release_s) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State and datapath registers with synchronous reset to zero / IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_zero   = res_zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU.
// The ALU model drives carry=1 on logic ops so result-carry masking is visible.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, res_valid, res_ready;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic [1:0] cmd_op, alu_opcode;
  logic       alu_carry, alu_zero, res_carry, res_zero;
`ifdef ALU_SEQ_ACC_EN
  logic       cmd_use_acc;
`endif
  logic [5:0] res_pk;
  logic [4:0] alu_wide;

  typedef struct packed {
    logic       acc;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [5:0] exp;   // {carry, zero, data}
  } vec_t;

  vec_t       tbl [11];
  logic [5:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
`ifdef ALU_SEQ_ACC_EN
    .cmd_use_acc(cmd_use_acc),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_zero   (res_zero)
  );

  assign res_pk = {res_carry, res_zero, res_data};

  // Behavioural ALU: sub carry is the borrow; logic ops deliberately raise carry.
  always_comb begin
    alu_wide = 5'd0;
    case (alu_opcode)
      2'b00:   alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_wide = {1'b1, alu_a & alu_b};
      2'b11:   alu_wide = {1'b1, alu_a | alu_b};
      default: alu_wide = 5'd0;
    endcase
    alu_out   = alu_wide[3:0];
    alu_carry = alu_wide[4];
    alu_zero  = (alu_wide[3:0] == 4'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int i);
    cmd_a  = tbl[i].a;
    cmd_b  = tbl[i].b;
    cmd_op = tbl[i].op;
`ifdef ALU_SEQ_ACC_EN
    cmd_use_acc = tbl[i].acc;
`endif
  endtask

  // Offer table entries first..first+n-1 for a fixed number of cycles; accepted ones are queued.
  task automatic offer(input int first, input int n, input int cycles, output int pushed);
    int   idx;
    logic rdy, vld;
    idx = first;
    for (int c = 0; c < cycles; c++) begin
      if (idx < first + n) begin
        drive_cmd(idx);
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      rdy = cmd_ready;
      vld = cmd_valid;
      tick();
      if (rdy && vld) begin
        exp_q.push_back(tbl[idx].exp);
        idx++;
      end
    end
    cmd_valid = 1'b0;
    pushed = idx - first;
  endtask

  // Collect n results with res_ready high; checks order, values and 2-cycle spacing.
  task automatic drain(input int n, input int budget);
    int got;
    int last;
    got  = 0;
    last = -1;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      if (res_valid) begin
        if (exp_q.size() > 0) begin
          check_eq("drain_data", res_pk, exp_q.pop_front());
        end else begin
          check_eq("drain_extra", 32'd1, 32'd0);
        end
        if (last >= 0) begin
          check_eq("drain_gap", cyc - last, 2);
        end
        last = cyc;
        got++;
      end
      tick();
    end
    check_eq("drain_count", got, n);
  endtask

  initial begin
    int p;
    int stale;
    int dir_idx [3];
    tbl[0]  = '{1'b0, 4'd1,  4'd2,  2'd0, 6'h03};
    tbl[1]  = '{1'b0, 4'd9,  4'd9,  2'd0, 6'h22};
    tbl[2]  = '{1'b0, 4'd7,  4'd7,  2'd1, 6'h10};
    tbl[3]  = '{1'b0, 4'd6,  4'd3,  2'd2, 6'h02};
    tbl[4]  = '{1'b0, 4'd4,  4'd8,  2'd3, 6'h0C};
    tbl[5]  = '{1'b0, 4'd2,  4'd5,  2'd1, 6'h2D};
    tbl[6]  = '{1'b0, 4'd15, 4'd1,  2'd0, 6'h30};
    tbl[7]  = '{1'b0, 4'd12, 4'd10, 2'd2, 6'h08};
    tbl[8]  = '{1'b0, 4'd3,  4'd4,  2'd0, 6'h07};
    tbl[9]  = '{1'b0, 4'd5,  4'd2,  2'd0, 6'h07};
    tbl[10] = '{1'b1, 4'd9,  4'd3,  2'd0, 6'h0A};
    dir_idx = '{6, 7, 5};

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 2'd0;
`ifdef ALU_SEQ_ACC_EN
    cmd_use_acc = 1'b0;
`endif

    // Reset: during and after
    tick();
    check_eq("rst_ready",  cmd_ready, 1);
    check_eq("rst_valid",  res_valid, 0);
    check_eq("rst_res",    res_pk, 0);
    check_eq("rst_alu",    {alu_a, alu_b, alu_opcode}, 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", cmd_ready, 1);
    check_eq("post_rst_valid", res_valid, 0);
    check_eq("post_rst_alu",   {alu_a, alu_b, alu_opcode}, 0);

    // Latency of a single add into an empty FIFO
    drive_cmd(8);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_eq("lat_n_alu_a", alu_a, 0);
    check_eq("lat_n_valid", res_valid, 0);
    tick();
    check_eq("lat_n1_alu", {alu_a, alu_b, alu_opcode}, {4'd3, 4'd4, 2'd0});
    check_eq("lat_n1_valid", res_valid, 0);
    tick();
    check_eq("lat_n2_valid", res_valid, 1);
    check_eq("lat_n2_res", res_pk, 6'h07);
    tick();
    tick();
    check_eq("hold_valid", res_valid, 1);
    check_eq("hold_res", res_pk, 6'h07);
    res_ready = 1'b1;
    tick();
    check_eq("release_valid", res_valid, 0);
    check_eq("operand_keep", alu_a, 3);

    // Carry/zero/masking and sub-borrow vectors
    foreach (dir_idx[k]) begin
      offer(dir_idx[k], 1, 1, p);
      check_eq("dir_pushed", p, 1);
      drain(1, 10);
    end

    // Backpressure: 6 offered, 1 in result register + 4 buffered
    res_ready = 1'b0;
    offer(0, 6, 10, p);
    check_eq("bp_pushed", p, 5);
    check_eq("bp_ready", cmd_ready, 0);
    check_eq("bp_valid", res_valid, 1);
    check_eq("bp_head", res_pk, tbl[0].exp);
    res_ready = 1'b1;
    drain(5, 30);

    // Reset while in RESP with a full FIFO
    res_ready = 1'b0;
    offer(0, 6, 10, p);
    exp_q.delete();
    check_eq("mid_valid_before", res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_valid", res_valid, 0);
    check_eq("mid_ready", cmd_ready, 1);
    check_eq("mid_outs", {alu_a, alu_b, alu_opcode, res_pk}, 0);
    res_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (res_valid) stale++;
      tick();
    end
    check_eq("mid_stale", stale, 0);

`ifdef ALU_SEQ_ACC_EN
    // Accumulator forwarding: 5+2=7, then acc+3=10
    offer(9, 2, 2, p);
    check_eq("acc_pushed", p, 2);
    drain(2, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream issue stage for the 4-bit combinational ALU. It accepts ALU commands (operands plus opcode) over a valid/ready handshake and buffers them in a small FIFO. It drives registered operands into the ALU one command at a time, then captures the ALU's result and flags into a result register presented downstream over a second valid/ready handshake. All ALU traffic in the datapath is serialised and flow-controlled here.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: FIFO can accept; equals not-full
- `cmd_a`, `cmd_b` in 4: operands
- `cmd_op` in 2: 00 add, 01 sub, 10 and, 11 or
- `cmd_use_acc` in 1: only with `ALU_SEQ_ACC_EN`; replace `cmd_a` with the accumulator
- `alu_a`, `alu_b` out 4: registered operands to the ALU
- `alu_opcode` out 2: registered opcode to the ALU
- `alu_out` in 4: ALU result
- `alu_carry` in 1: ALU carry
- `alu_zero` in 1: ALU zero flag
- `res_valid` out 1: result held
- `res_ready` in 1: consumer accepts
- `res_data` out 4: captured result
- `res_carry` out 1: captured carry
- `res_zero` out 1: captured zero flag

## Operation
- Push: a push occurs on the rising edge when `cmd_valid && cmd_ready`. `cmd_ready` depends only on the registered count, not on a same-cycle pop. A full FIFO never accepts, even while popping.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, load `alu_a`/`alu_b`/`alu_opcode`, and go to EXEC.
  - EXEC: exactly one cycle. The ALU settles from the registered operands. At the end of the cycle, capture `res_data=alu_out` and `res_zero=alu_zero`. Set `res_carry=alu_carry` for ops 00/01 and force it to 0 for ops 10/11. Set `res_valid=1` and go to RESP.
  - RESP: hold all `res_*` stable until `res_valid && res_ready`. On that handshake, clear `res_valid`. If the FIFO is non-empty, pop and load the next command and go to EXEC; otherwise go to IDLE.
- Operand registers keep their last value when no command is being loaded.
- Commands are executed strictly in FIFO order. None are dropped or duplicated.
- Reset, including mid-operation:
  - FSM goes to IDLE and the FIFO is emptied; buffered commands are discarded.
  - All outputs go to 0, except `cmd_ready`, which is 1.
  - The accumulator clears to 0.
- Pointers wrap modulo `DEPTH`. The count has width `$clog2(DEPTH+1)` and ranges 0..`DEPTH`.

## Timing
- Latency: a command pushed at edge N into an empty FIFO, with the FSM in IDLE, gives the following sequence.
  - Edge N+1: operands appear on `alu_*`.
  - Edge N+2: `res_valid` rises.
- Throughput is one result per 2 cycles with `res_ready` held high.
- `res_*` and `alu_*` are registered outputs. `cmd_ready` is derived from registered state only, so there is no combinational path from input to output.
- Pushes and pops of different entries in the same cycle are allowed. The count is unchanged when both happen.

## Configuration
- Macro `ALU_SEQ_ACC_EN`, compiled in:
  - Adds the `cmd_use_acc` port, stored per FIFO entry.
  - Adds a 4-bit accumulator that loads `res_data` on every EXEC capture.
  - When a popped entry has `use_acc=1`, `alu_a` is taken from the accumulator value at the pop edge instead of the stored operand. Back-to-back dependent commands therefore see the previous result.
- Macro not defined: no port, no accumulator, and FIFO entries are 10 bits wide.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode localparams `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`.
  - The FSM state enum.
  - The ALU data width constant (4).
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO with push/pop, full/empty and count. The FSM and result register stay in the top level.

## Test plan
- Reset: assert `rst` for 2 cycles.
  - During and after reset: `cmd_ready=1`, `res_valid=0`, and all `res_*`/`alu_*` are 0.
- Add:
  - Push a=3, b=4, op=00 at edge N.
  - Edge N+2: `res_valid=1`, `res_data=7`, `res_carry=0`, `res_zero=0`.
- Carry/zero:
  - Push a=15, b=1, op=00: `res_data=0`, `res_carry=1`, `res_zero=1`.
  - Push a=12, b=10, op=10: `res_data=8`, `res_carry=0` regardless of `alu_carry`.
- Backpressure:
  - Hold `res_ready=0` and offer 6 commands.
  - Required: one command in the result register, `DEPTH` commands in the FIFO, then `cmd_ready=0`.
  - Release `res_ready`: results emerge in push order, one every 2 cycles, with no loss.
- Reset mid-operation:
  - Fill the FIFO, then assert `rst` during RESP.
  - Next cycle: `res_valid=0`, FIFO empty, and no stale results appear afterwards.
- With `ALU_SEQ_ACC_EN`:
  - Push (5, 2, op 00).
  - Then push (x, 3, op 00, `use_acc=1`).
  - Required results: 7, then 10.
